// File: rtl/instr_encoder.sv
// Packs field-level instruction requests into 16-bit instruction words and streams
// them to instruction memory at sequential addresses through a 4-entry FIFO.
module instr_encoder #(
  parameter int          P_AW       = 8,
  parameter logic [3:0]  P_WRITE_OP = 4'h8
) (
  input  logic            I_clk,
  input  logic            I_reset_n,
  input  logic            I_start,
  input  logic [P_AW-1:0] I_base_addr,
  input  logic [P_AW:0]   I_count,
  input  logic            I_valid,
  output logic            O_ready,
  input  logic [3:0]      I_opcode,
  input  logic [2:0]      I_rD,
  input  logic [2:0]      I_rA,
  input  logic [2:0]      I_rB,
  input  logic            I_mode,
  input  logic [7:0]      I_imm,
  input  logic            I_imm_form,
  output logic            O_we,
  output logic [P_AW-1:0] O_addr,
  output logic [15:0]     O_data,
  input  logic            I_mem_ready,
  output logic            O_busy,
  output logic            O_done,
  output logic            O_error
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  localparam logic [P_AW-1:0] ADDR_ONE = P_AW'(1);
  localparam logic [P_AW:0]   CNT_ONE  = (P_AW+1)'(1);

  logic            state_q, state_n;
  logic [P_AW-1:0] addr_q, addr_n;
  logic [P_AW:0]   cnt_q, cnt_n, acc_q, acc_n, wrs_q, wrs_n;
  logic [1:0]      wptr_q, wptr_n, rptr_q, rptr_n;
  logic [2:0]      occ_q, occ_n;
  logic [15:0]     fifo_mem [4];

  logic        ready_n, we_n, done_n, err_n;
  logic [15:0] data_n, enc_word;
  logic        hs, misaligned, push, pop;

  // A misaligned WRITE still completes its handshake but never reaches the FIFO.
  assign misaligned = (I_opcode == P_WRITE_OP) && (I_imm[1:0] != 2'b00);
  assign hs         = O_ready && I_valid;
  assign push       = hs && !misaligned;
  assign pop        = O_we && I_mem_ready;

  assign O_addr = addr_q;
  assign O_busy = state_q;

  always_comb begin
    enc_word = {I_opcode, I_rD, I_mode, I_rA, I_rB, 2'b00};
    if (I_opcode == P_WRITE_OP)
      enc_word = {I_opcode, I_imm[7:5], I_mode, I_rA, 2'b00, I_imm[4:2]};
    else if (I_imm_form)
      enc_word = {I_opcode, I_rD, I_mode, I_imm};
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_n = state_q;
    addr_n  = addr_q;
    cnt_n   = cnt_q;
    acc_n   = acc_q;
    wrs_n   = wrs_q;
    wptr_n  = wptr_q;
    rptr_n  = rptr_q;
    err_n   = O_error;
    done_n  = 1'b0;
    occ_n   = occ_q + 3'(push) - 3'(pop);

    if (push) begin
      wptr_n = wptr_q + 2'd1;
      acc_n  = acc_q + CNT_ONE;
    end
    if (pop) begin
      rptr_n = rptr_q + 2'd1;
      addr_n = addr_q + ADDR_ONE;
      wrs_n  = wrs_q + CNT_ONE;
    end
    if (hs && misaligned) err_n = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (I_start) begin
          addr_n = I_base_addr;
          cnt_n  = I_count;
          acc_n  = '0;
          wrs_n  = '0;
          err_n  = 1'b0;
          if (I_count == '0) done_n  = 1'b1;
          else               state_n = ST_RUN;
        end
      end
      default: begin
        if (pop && (wrs_n == cnt_q)) begin
          done_n  = 1'b1;
          state_n = ST_IDLE;
        end
      end
    endcase

    ready_n = (state_n == ST_RUN) && (occ_n != 3'd4) && (acc_n < cnt_n);
    we_n    = (state_n == ST_RUN) && (occ_n != 3'd0);
    // The next head is the incoming word only when the FIFO drains to empty this cycle.
    data_n  = O_data;
    if (we_n)
      data_n = ((occ_q - 3'(pop)) == 3'd0) ? enc_word : fifo_mem[rptr_n];
  end

  // NOTE: the FIFO storage has no reset; occupancy and pointers alone decide what is valid.
  always_ff @(posedge I_clk) begin
    if (push) fifo_mem[wptr_q] <= enc_word;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      wrs_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      occ_q   <= '0;
      O_ready <= 1'b0;
      O_we    <= 1'b0;
      O_data  <= '0;
      O_done  <= 1'b0;
      O_error <= 1'b0;
    end else begin
      state_q <= state_n;
      addr_q  <= addr_n;
      cnt_q   <= cnt_n;
      acc_q   <= acc_n;
      wrs_q   <= wrs_n;
      wptr_q  <= wptr_n;
      rptr_q  <= rptr_n;
      occ_q   <= occ_n;
      O_ready <= ready_n;
      O_we    <= we_n;
      O_data  <= data_n;
      O_done  <= done_n;
      O_error <= err_n;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: table-driven request vectors plus hand-written
// multi-cycle sequences, with a write scoreboard checked as memory writes complete.
module tb_instr_encoder;

  logic        I_clk = 1'b0;
  logic        I_reset_n;
  logic        I_start;
  logic [7:0]  I_base_addr;
  logic [8:0]  I_count;
  logic        I_valid;
  logic        O_ready;
  logic [3:0]  I_opcode;
  logic [2:0]  I_rD, I_rA, I_rB;
  logic        I_mode;
  logic [7:0]  I_imm;
  logic        I_imm_form;
  logic        O_we;
  logic [7:0]  O_addr;
  logic [15:0] O_data;
  logic        I_mem_ready;
  logic        O_busy, O_done, O_error;

  instr_encoder #(.P_AW(8), .P_WRITE_OP(4'h8)) dut (
    .I_clk(I_clk), .I_reset_n(I_reset_n), .I_start(I_start),
    .I_base_addr(I_base_addr), .I_count(I_count),
    .I_valid(I_valid), .O_ready(O_ready),
    .I_opcode(I_opcode), .I_rD(I_rD), .I_rA(I_rA), .I_rB(I_rB),
    .I_mode(I_mode), .I_imm(I_imm), .I_imm_form(I_imm_form),
    .O_we(O_we), .O_addr(O_addr), .O_data(O_data), .I_mem_ready(I_mem_ready),
    .O_busy(O_busy), .O_done(O_done), .O_error(O_error)
  );

  always #5 I_clk = ~I_clk;

  typedef struct {
    logic [3:0]  op;
    logic [2:0]  rd, ra, rb;
    logic        mode;
    logic [7:0]  imm;
    logic        form;
    logic [15:0] exp_data;
    logic        exp_wr;
  } vec_t;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
  } sb_t;

  vec_t       vecs [10];
  sb_t        sb_q [$];
  int         n_vec    = 0;
  int         n_bad    = 0;
  int         n_writes = 0;
  logic [7:0] exp_addr = 8'h00;
  bit         mr_random = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Write monitor: every completed memory write must match the scoreboard head.
  always @(negedge I_clk) begin
    if (I_reset_n && O_we && I_mem_ready) begin
      n_writes++;
      if (sb_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_write: addr=%h data=%h, no write expected", O_addr, O_data);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        check("wr_addr", 32'(O_addr), 32'(e.addr));
        check("wr_data", 32'(O_data), 32'(e.data));
      end
    end
  end

  initial begin
    forever begin
      @(posedge I_clk);
      #1;
      if (mr_random) I_mem_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_run(input logic [7:0] base, input logic [8:0] cnt);
    @(posedge I_clk);
    #1;
    I_start     = 1'b1;
    I_base_addr = base;
    I_count     = cnt;
    @(posedge I_clk);
    #1;
    I_start  = 1'b0;
    exp_addr = base;
    if (cnt == 9'd0) check("zero_count_done", 32'(O_done), 32'd1);
    else             check("busy_rise", 32'(O_busy), 32'd1);
    check("err_cleared", 32'(O_error), 32'd0);
  endtask

  task automatic send(input vec_t v);
    bit got;
    got        = 1'b0;
    I_opcode   = v.op;
    I_rD       = v.rd;
    I_rA       = v.ra;
    I_rB       = v.rb;
    I_mode     = v.mode;
    I_imm      = v.imm;
    I_imm_form = v.form;
    I_valid    = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge I_clk);
      if (O_ready) begin
        got = 1'b1;
        if (v.exp_wr) begin
          sb_q.push_back('{exp_addr, v.exp_data});
          exp_addr++;
        end
      end
      @(posedge I_clk);
      #1;
    end
    I_valid = 1'b0;
    if (!got) fail_now("send_handshake");
  endtask

  task automatic wait_done(input int max_cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      @(negedge I_clk);
      if (O_done) seen = 1'b1;
    end
    if (!seen) begin
      fail_now("wait_done");
    end else begin
      check("busy_fall_with_done", 32'(O_busy), 32'd0);
      check("done_fifo_drained", 32'(O_we), 32'd0);
      @(negedge I_clk);
      check("done_one_cycle", 32'(O_done), 32'd0);
    end
  endtask

  function automatic logic [15:0] bp_word(input int i);
    return {4'h4, 3'(i), 1'b0, 8'(8'h30 + i)};
  endfunction

  task automatic drive_bp(input int i);
    I_opcode   = 4'h4;
    I_rD       = 3'(i);
    I_rA       = 3'd0;
    I_rB       = 3'd0;
    I_mode     = 1'b0;
    I_imm      = 8'(8'h30 + i);
    I_imm_form = 1'b1;
  endtask

  initial begin
    int w0;
    int acc;

    //           op    rd    ra    rb    mode  imm    form  data      wr
    vecs[0] = '{4'h1, 3'd3, 3'd5, 3'd2, 1'b1, 8'h00, 1'b0, 16'h17A8, 1'b1};
    vecs[1] = '{4'h2, 3'd7, 3'd0, 3'd0, 1'b0, 8'h5C, 1'b1, 16'h2E5C, 1'b1};
    vecs[2] = '{4'h8, 3'd0, 3'd1, 3'd0, 1'b0, 8'hB4, 1'b1, 16'h8A25, 1'b1};
    vecs[3] = '{4'h8, 3'd0, 3'd1, 3'd0, 1'b0, 8'hB6, 1'b0, 16'h0000, 1'b0};
    vecs[4] = '{4'hF, 3'd0, 3'd7, 3'd7, 1'b0, 8'hAA, 1'b0, 16'hF0FC, 1'b1};
    vecs[5] = '{4'h0, 3'd5, 3'd0, 3'd0, 1'b1, 8'hFF, 1'b1, 16'h0BFF, 1'b1};
    vecs[6] = '{4'h8, 3'd0, 3'd6, 3'd0, 1'b1, 8'h1C, 1'b0, 16'h81C7, 1'b1};
    vecs[7] = '{4'hA, 3'd1, 3'd2, 3'd4, 1'b0, 8'h00, 1'b0, 16'hA250, 1'b1};
    vecs[8] = '{4'h8, 3'd0, 3'd0, 3'd0, 1'b0, 8'h03, 1'b1, 16'h0000, 1'b0};
    vecs[9] = '{4'h3, 3'd2, 3'd0, 3'd0, 1'b0, 8'h80, 1'b1, 16'h3480, 1'b1};

    I_reset_n = 1'b0; I_start = 1'b0; I_base_addr = '0; I_count = '0;
    I_valid = 1'b0; I_opcode = '0; I_rD = '0; I_rA = '0; I_rB = '0;
    I_mode = 1'b0; I_imm = '0; I_imm_form = 1'b0; I_mem_ready = 1'b1;

    repeat (2) @(posedge I_clk);
    #1;
    check("rst_ready", 32'(O_ready), 32'd0);
    check("rst_we",    32'(O_we),    32'd0);
    check("rst_addr",  32'(O_addr),  32'd0);
    check("rst_data",  32'(O_data),  32'd0);
    check("rst_busy",  32'(O_busy),  32'd0);
    check("rst_done",  32'(O_done),  32'd0);
    check("rst_error", 32'(O_error), 32'd0);
    I_reset_n = 1'b1;

    // Register form, single word.
    w0 = n_writes;
    start_run(8'h10, 9'd1);
    send(vecs[0]);
    wait_done(20);
    check("single_writes", 32'(n_writes - w0), 32'd1);

    // Immediate form followed by a WRITE split-immediate word.
    w0 = n_writes;
    start_run(8'h30, 9'd2);
    send(vecs[1]);
    send(vecs[2]);
    wait_done(20);
    check("split_writes", 32'(n_writes - w0), 32'd2);

    // Full table with random memory back-pressure; two misaligned WRITEs are dropped.
    w0 = n_writes;
    mr_random = 1'b1;
    start_run(8'h20, 9'd8);
    for (int i = 0; i < 10; i++) begin
      send(vecs[i]);
      if (i == 2) check("err_before_misaligned", 32'(O_error), 32'd0);
      if (i == 3) check("err_after_misaligned", 32'(O_error), 32'd1);
    end
    wait_done(400);
    mr_random = 1'b0;
    check("table_writes", 32'(n_writes - w0), 32'd8);
    check("err_sticky", 32'(O_error), 32'd1);
    @(posedge I_clk);
    #1;
    I_mem_ready = 1'b1;

    // Back-pressure: memory stalled for 10 cycles with I_valid held high.
    w0 = n_writes;
    I_mem_ready = 1'b0;
    start_run(8'h40, 9'd6);
    acc = 0;
    drive_bp(acc);
    I_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge I_clk);
      if (O_ready) begin
        sb_q.push_back('{exp_addr, bp_word(acc)});
        exp_addr++;
        acc++;
      end
      @(posedge I_clk);
      #1;
      drive_bp(acc);
    end
    check("bp_accepted", 32'(acc), 32'd4);
    check("bp_ready_low", 32'(O_ready), 32'd0);
    check("bp_we_high", 32'(O_we), 32'd1);
    check("bp_addr_hold", 32'(O_addr), 32'h40);
    check("bp_data_hold", 32'(O_data), 32'(bp_word(0)));
    I_mem_ready = 1'b1;
    for (int c = 0; c < 50 && acc < 6; c++) begin
      @(negedge I_clk);
      if (O_ready) begin
        sb_q.push_back('{exp_addr, bp_word(acc)});
        exp_addr++;
        acc++;
      end
      @(posedge I_clk);
      #1;
      drive_bp(acc);
    end
    I_valid = 1'b0;
    check("bp_total_accepted", 32'(acc), 32'd6);
    wait_done(40);
    check("bp_writes", 32'(n_writes - w0), 32'd6);

    // Address wrap, then a zero-count run.
    w0 = n_writes;
    start_run(8'hFE, 9'd3);
    send(vecs[4]);
    send(vecs[5]);
    send(vecs[6]);
    wait_done(20);
    check("wrap_writes", 32'(n_writes - w0), 32'd3);
    w0 = n_writes;
    start_run(8'h55, 9'd0);
    check("zero_no_busy", 32'(O_busy), 32'd0);
    repeat (3) @(negedge I_clk);
    check("zero_no_writes", 32'(n_writes - w0), 32'd0);
    check("zero_done_pulse", 32'(O_done), 32'd0);

    // Reset with two words buffered behind a stalled memory.
    I_mem_ready = 1'b0;
    start_run(8'h60, 9'd4);
    send(vecs[7]);
    send(vecs[9]);
    #2;
    I_reset_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(O_ready), 32'd0);
    check("mid_rst_we",    32'(O_we),    32'd0);
    check("mid_rst_addr",  32'(O_addr),  32'd0);
    check("mid_rst_data",  32'(O_data),  32'd0);
    check("mid_rst_busy",  32'(O_busy),  32'd0);
    check("mid_rst_done",  32'(O_done),  32'd0);
    check("mid_rst_error", 32'(O_error), 32'd0);
    sb_q.delete();
    @(posedge I_clk);
    #1;
    I_reset_n   = 1'b1;
    I_mem_ready = 1'b1;
    w0 = n_writes;
    start_run(8'h70, 9'd1);
    send(vecs[1]);
    wait_done(20);
    check("post_rst_writes", 32'(n_writes - w0), 32'd1);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
